data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Data-memory responder at the far end of the MEM-stage load/store request interface.
- Accepts word requests (ce/we/addr/wdata) from MEM and stores words in an internal RAM.
- Returns read data for loads.
- Holds the pipeline through a stall request for the configurable access time. Sits between the MEM stage and the pipeline control (stall) unit.

Parameters:
- ADDR_W, 10, word-index width; memory depth is 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 1, number of BUSY cycles per access; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; rst is synchronous, active-high
- ce_i  in  1  chip enable; request valid (ChipEnable = 1)
- we_i  in  1  1 = store, 0 = load
- addr_i  in  32  byte address of request
- wdata_i  in  32  store data
- rdata_o  out  32  load data; valid only in DONE, else 0
- stallreq_o  out  1  1 = hold pipeline; MEM must keep the request stable
- align_err_o  out  1  1-cycle pulse in DONE when the captured address had addr[1:0] != 0

Behaviour:
- Reset, sampled at the clk edge:
  - state <= IDLE, cnt <= 0, rdata_q <= 0, err_q <= 0, request registers <= 0.
  - Outputs after reset: rdata_o = 0, stallreq_o = 0, align_err_o = 0.
  - RAM contents are not cleared.
- Reset mid-access: the access is abandoned. A store not yet committed is not written.
- Word index is addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias modulo 4*2^ADDR_W.
- State machine, 2-bit encoding. IDLE = 0, BUSY = 1, DONE = 2; value 3 decodes as IDLE.
- IDLE:
  - stallreq_o = ce_i (combinational), rdata_o = 0.
  - If ce_i = 1 at the edge: capture addr_i, we_i, wdata_i into request registers; cnt <= WAIT_CYCLES-1; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - stallreq_o = 1. ce_i, we_i, addr_i and wdata_i are ignored; only the captured copy is used.
  - If cnt != 0: cnt <= cnt-1 and stay in BUSY.
  - If cnt == 0, perform the access at this edge and go to DONE:
    - Aligned store: mem[idx] <= wdata_q.
    - Aligned load: rdata_q <= mem[idx].
    - Misaligned store: suppressed, RAM unchanged.
    - Misaligned load: rdata_q <= 0.
    - err_q <= misaligned.
- DONE:
  - stallreq_o = 0, rdata_o = rdata_q (0 for stores), align_err_o = err_q.
  - Next state is always IDLE; rdata_q and err_q are cleared at that edge.
  - The pipeline advances at the end of DONE. A request in the following cycle is a new access.
- Timing per access: stall cycles = WAIT_CYCLES+1, then 1 DONE cycle.
  - With WAIT_CYCLES = 1: request cycle T0 stall, T1 stall, T2 data valid and no stall.
- ce_i dropping while in BUSY (flush) does not cancel the access; it completes normally.
- Back-to-back requests: DONE -> IDLE adds no extra bubble. IDLE sees the next ce_i in the cycle after DONE.
- Read-after-write to the same word returns the stored value, because the write commits before the later read's BUSY edge.

Decomposition:
- Shared defines include (the existing global defines file):
  - State encodings DMEM_IDLE, DMEM_BUSY, DMEM_DONE.
  - Existing constants ChipEnable/ChipDisable, WriteEnable/WriteDisable, ZeroWord, RegBus, reused.
- One sub-module: data_mem_array.
  - Single-port 2^ADDR_W x 32 RAM.
  - Synchronous write; synchronous read into an output register with a read-enable.
  - Infers block RAM.
- The FSM, counter and request registers stay in data_mem_responder.

Test Plan:
- Store then load, WAIT_CYCLES = 1:
  - Store 0xDEADBEEF to 0x00000010 -> stallreq_o = 1 for 2 cycles, DONE with rdata_o = 0.
  - Load from 0x00000010 -> stallreq_o = 1 for 2 cycles, then rdata_o = 0xDEADBEEF for exactly 1 cycle with stallreq_o = 0.
- Misaligned access:
  - Store 0x12345678 to 0x00000012 -> align_err_o pulses in DONE and RAM is unchanged.
  - Load from 0x00000010 -> 0xDEADBEEF; load from 0x00000013 -> rdata_o = 0 and align_err_o = 1.
- Alias and wrap with ADDR_W = 10:
  - Store 0xA5A5A5A5 to 0x00001004 -> a load from 0x00000004 returns 0xA5A5A5A5.
- Reset mid-access:
  - Store 0x11111111 to 0x20, asserting rst in the first BUSY cycle -> next cycle all outputs 0, state IDLE.
  - A later load from 0x20 returns the old contents, not 0x11111111.
- Back-to-back with WAIT_CYCLES = 3 and ce_i held high with changing addresses:
  - Each access stalls exactly 4 cycles and DONE is 1 cycle.
  - Inputs changed during BUSY are ignored: the captured address is used.
  - ce_i dropped during BUSY still completes the access.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder slice.
// Holds the state encoding, the chip/write-enable constants and the bus
// width that the MEM-stage request interface has always used, plus a small
// helper that decides whether a byte address is word aligned.
package data_mem_responder_pkg;

  localparam int RegBus = 32;

  localparam logic ChipEnable   = 1'b1;
  localparam logic ChipDisable  = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

  // Value 2'd3 is never produced; the FSM treats it like DMEM_IDLE.
  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_e;

  // A word access is misaligned when either of the two byte-offset bits is set.
  function automatic logic addr_misaligned(input logic [1:0] byte_off);
    return (byte_off != 2'b00);
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port word RAM behind the data-memory responder.
// Synchronous write; synchronous read into an output register that loads
// only when re is high and is cleared by rd_clr (rd_clr has priority).
// Ports:
//   clk     rising-edge clock
//   we      write enable: mem[addr] <= wdata at the edge
//   re      read enable: rdata <= mem[addr] at the edge
//   rd_clr  clear the read register to zero at the edge
//   addr    word index
//   wdata   write data
//   rdata   registered read data
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic              rd_clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [RegBus-1:0] wdata,
  output logic [RegBus-1:0] rdata
);

  logic [RegBus-1:0] mem_r [0:(2**ADDR_W)-1];
  logic [RegBus-1:0] rdata_r;

  // Storage write port; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read output register with a synchronous clear.
  always_ff @(posedge clk) begin
    if (rd_clr) begin
      rdata_r <= ZeroWord;
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder at the far end of the MEM-stage load/store interface.
// Captures a word request, stalls the pipeline for WAIT_CYCLES+1 cycles,
// performs the access on the last BUSY edge and presents the result for a
// single DONE cycle with the stall released.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   ce_i         request valid
//   we_i         1 = store, 0 = load
//   addr_i       byte address; word index is addr_i[ADDR_W+1:2]
//   wdata_i      store data
//   rdata_o      load data in DONE, zero otherwise
//   stallreq_o   hold the pipeline
//   align_err_o  DONE-cycle pulse for a misaligned captured address
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic              we_i,
  input  logic [RegBus-1:0] addr_i,
  input  logic [RegBus-1:0] wdata_i,
  output logic [RegBus-1:0] rdata_o,
  output logic              stallreq_o,
  output logic              align_err_o
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  dmem_state_e       state_r, state_s;
  logic [3:0]        cnt_r, cnt_s;
  logic              req_we_r;
  logic [ADDR_W+1:0] req_addr_r;
  logic [RegBus-1:0] req_wdata_r;
  logic              err_r, err_s;
  logic              capture_s;
  logic              stall_s;
  logic              done_s;

  logic [ADDR_W-1:0] idx_s;
  logic              misal_s;
  logic              access_s;
  logic              ram_we_s;
  logic              ram_re_s;
  logic              ram_clr_s;
  logic [RegBus-1:0] ram_rdata_s;

  // Upper address bits only alias; fold them away so they are visibly unused.
  logic unused_addr_s;
  assign unused_addr_s = ^addr_i[RegBus-1:ADDR_W+2];

  assign idx_s   = req_addr_r[ADDR_W+1:2];
  assign misal_s = addr_misaligned(req_addr_r[1:0]);

  // The access edge is the BUSY edge with the counter exhausted. Reset on the
  // same edge abandons it, so a pending store is never committed.
  assign access_s  = (state_r == DMEM_BUSY) && (cnt_r == 4'd0) && !rst;
  assign ram_we_s  = access_s && (req_we_r == WriteEnable) && !misal_s;
  assign ram_re_s  = access_s && (req_we_r == WriteDisable) && !misal_s;
  // Read register holds zero except after an aligned load; it is cleared on
  // reset, when leaving DONE, and on store or misaligned accesses.
  assign ram_clr_s = rst || (state_r == DMEM_DONE)
                   || (access_s && ((req_we_r == WriteEnable) || misal_s));

  data_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk    (clk),
    .we     (ram_we_s),
    .re     (ram_re_s),
    .rd_clr (ram_clr_s),
    .addr   (idx_s),
    .wdata  (req_wdata_r),
    .rdata  (ram_rdata_s)
  );

  // Next-state, counter and stall decode.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    err_s     = err_r;
    capture_s = 1'b0;
    stall_s   = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      DMEM_BUSY: begin
        stall_s = 1'b1;
        if (cnt_r != 4'd0) begin
          cnt_s = cnt_r - 4'd1;
        end else begin
          state_s = DMEM_DONE;
          err_s   = misal_s;
        end
      end
      DMEM_DONE: begin
        done_s  = 1'b1;
        state_s = DMEM_IDLE;
        err_s   = 1'b0;
      end
      default: begin
        // IDLE, and the unused encoding 2'd3 behaves identically.
        stall_s = ce_i;
        if (ce_i == ChipEnable) begin
          capture_s = 1'b1;
          cnt_s     = WAIT_LOAD;
          state_s   = DMEM_BUSY;
        end else begin
          state_s = DMEM_IDLE;
        end
      end
    endcase
  end

  // State, counter, error flag and request capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= DMEM_IDLE;
      cnt_r       <= 4'd0;
      err_r       <= 1'b0;
      req_we_r    <= WriteDisable;
      req_addr_r  <= '0;
      req_wdata_r <= ZeroWord;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
      if (capture_s) begin
        req_we_r    <= we_i;
        req_addr_r  <= addr_i[ADDR_W+1:0];
        req_wdata_r <= wdata_i;
      end
    end
  end

  assign stallreq_o  = stall_s;
  assign rdata_o     = done_s ? ram_rdata_s : ZeroWord;
  assign align_err_o = done_s ? err_r : 1'b0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance with WAIT_CYCLES=1
// and one with WAIT_CYCLES=3. The driver pushes the hand-computed response
// of each request; the monitor pops it when a DONE cycle appears.
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stalls;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ce    [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        stall [2];
  logic        aerr  [2];

  exp_t q0[$];
  exp_t q1[$];
  int   compared   = 0;
  int   mismatched = 0;

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst), .ce_i(ce[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .rdata_o(rdata[0]), .stallreq_o(stall[0]),
    .align_err_o(aerr[0])
  );

  data_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst(rst), .ce_i(ce[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .rdata_o(rdata[1]), .stallreq_o(stall[1]),
    .align_err_o(aerr[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts consecutive stall cycles; the first non-stall cycle after
  // a stall run is DONE and is compared against the queued expectation.
  initial begin
    int   run   [2];
    bit   after [2];
    exp_t e;
    run[0] = 0; run[1] = 0; after[0] = 1'b0; after[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          run[d]   = 0;
          after[d] = 1'b0;
        end else begin
          if (after[d]) begin
            check($sformatf("post_done_rdata[%0d]", d), rdata[d], 32'h0);
            check($sformatf("post_done_err[%0d]", d), {31'h0, aerr[d]}, 32'h0);
            after[d] = 1'b0;
          end
          if (stall[d]) begin
            run[d]++;
          end else if (run[d] > 0) begin
            if (d == 0 && q0.size() > 0) begin
              e = q0.pop_front();
            end else if (d == 1 && q1.size() > 0) begin
              e = q1.pop_front();
            end else begin
              e.rdata = 32'hxxxx_xxxx; e.err = 1'bx; e.stalls = -1;
              compared++; mismatched++;
              $display("FAIL unexpected_done[%0d]: got a DONE cycle, expected none", d);
            end
            if (e.stalls >= 0) begin
              check($sformatf("rdata[%0d]", d), rdata[d], e.rdata);
              check($sformatf("align_err[%0d]", d), {31'h0, aerr[d]}, {31'h0, e.err});
              check($sformatf("stall_cycles[%0d]", d), 32'(run[d]), 32'(e.stalls));
            end
            run[d]   = 0;
            after[d] = 1'b1;
          end
        end
      end
    end
  end

  // Issue one request and hold it until the DONE cycle. mode 1 scrambles the
  // inputs while BUSY, mode 2 drops ce_i while BUSY.
  task automatic access(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er,
                        input logic ee, input int mode);
    exp_t e;
    int   n;
    e.rdata = er; e.err = ee; e.stalls = (d == 0) ? 2 : 4;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    ce[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (stall[d] && n >= 2 && mode == 1) begin
        addr[d]  = addr[d] ^ 32'h0000_0004;
        wdata[d] = ~wdata[d];
        we[d]    = ~we[d];
      end
      if (stall[d] && n >= 2 && mode == 2) ce[d] = 1'b0;
    end while (stall[d] && n < 50);
    if (stall[d]) begin
      compared++; mismatched++;
      $display("FAIL timeout[%0d]: stall still high after %0d cycles, expected release", d, n);
    end
  endtask

  task automatic go_idle();
    ce[0] = 1'b0; ce[1] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ce[d] = 1'b0; we[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_rdata[%0d]", d), rdata[d], 32'h0);
      check($sformatf("reset_stall[%0d]", d), {31'h0, stall[d]}, 32'h0);
      check($sformatf("reset_err[%0d]", d), {31'h0, aerr[d]}, 32'h0);
    end

    // WAIT_CYCLES = 1: store/load, misalignment, aliasing.
    access(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 0);
    go_idle();
    access(0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 0);
    access(0, 1'b1, 32'h0000_0012, 32'h1234_5678, 32'h0,         1'b1, 0);
    access(0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 0);
    access(0, 1'b0, 32'h0000_0013, 32'h0,         32'h0,         1'b1, 0);
    access(0, 1'b1, 32'h0000_1004, 32'hA5A5_A5A5, 32'h0,         1'b0, 0);
    access(0, 1'b0, 32'h0000_0004, 32'h0,         32'hA5A5_A5A5, 1'b0, 0);
    access(0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0,         1'b0, 0);
    go_idle();

    // Reset during the first BUSY cycle of a store abandons it.
    ce[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0000_0020; wdata[0] = 32'h1111_1111;
    @(posedge clk); #1;
    rst = 1'b1; ce[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_rdata", rdata[0], 32'h0);
    check("midrst_stall", {31'h0, stall[0]}, 32'h0);
    check("midrst_err", {31'h0, aerr[0]}, 32'h0);
    access(0, 1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 1'b0, 0);
    go_idle();

    // WAIT_CYCLES = 3: back-to-back with ce_i held high.
    access(1, 1'b1, 32'h0000_0040, 32'h0101_0101, 32'h0,         1'b0, 1);
    access(1, 1'b0, 32'h0000_0040, 32'h0,         32'h0101_0101, 1'b0, 0);
    access(1, 1'b1, 32'h0000_0044, 32'h0202_0202, 32'h0,         1'b0, 2);
    access(1, 1'b0, 32'h0000_0044, 32'h0,         32'h0202_0202, 1'b0, 1);
    access(1, 1'b0, 32'h0000_0040, 32'h0,         32'h0101_0101, 1'b0, 0);
    access(1, 1'b0, 32'h0000_0046, 32'h0,         32'h0,         1'b1, 0);
    go_idle();

    repeat (4) @(posedge clk);
    #1;
    check("drain_q0", 32'(q0.size()), 32'h0);
    check("drain_q1", 32'(q1.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
